atm_arbiter: RTL

ATM_ARBITER -- requirements
Module: atm_arbiter

---
 rtl/atm_arbiter_if.sv | 28 ++
 rtl/atm_arbiter.sv | 136 +++++++++++++
 2 files changed

// File: rtl/atm_arbiter_if.sv
// Bus between the four ATM terminals and the shared-balance arbiter.
// The arbiter is the slave; the terminal side (or a testbench) is the master.
interface atm_arbiter_if;
  logic         cargarBalance;
  logic [63:0]  balanceInicial;
  logic [3:0]   req;
  logic [3:0]   tipoTrans;
  logic [127:0] monto;
  logic [3:0]   grant;
  logic [3:0]   ack;
  logic         balanceActualizado;
  logic         entregarDinero;
  logic         fondosInsuficientes;
  logic [63:0]  balance;
  logic         ocupado;

  modport slave (
    input  cargarBalance, balanceInicial, req, tipoTrans, monto,
    output grant, ack, balanceActualizado, entregarDinero, fondosInsuficientes,
           balance, ocupado
  );

  modport master (
    output cargarBalance, balanceInicial, req, tipoTrans, monto,
    input  grant, ack, balanceActualizado, entregarDinero, fondosInsuficientes,
           balance, ocupado
  );
endinterface

// File: rtl/atm_arbiter.sv
// Round-robin arbiter giving four ATM terminals serialized access to one
// shared 64-bit balance; deposits saturate, withdrawals are checked for funds.
module atm_arbiter (
  input logic         clk,
  input logic         rst,
  atm_arbiter_if.slave bus
);

  // One-hot so that any corrupted encoding is recognizable and falls to IDLE.
  typedef enum logic [3:0] {
    IDLE  = 4'b0001,
    GRANT = 4'b0010,
    EXEC  = 4'b0100,
    RESP  = 4'b1000
  } state_t;

  state_t      state, state_nxt;
  logic [1:0]  ptr;
  logic [1:0]  idx;
  logic        retiro_q;
  logic [31:0] monto_q;
  logic [63:0] balance_q;
  logic        upd_q, ent_q, ins_q;

  logic [1:0]  pick;
  logic [1:0]  cand;
  logic        pick_vld;
  logic        start;
  logic [64:0] sum;
  logic        enough;

  // Round-robin search ptr+1 .. ptr+4 (mod 4); the first hit wins.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    pick     = '0;
    pick_vld = 1'b0;
    cand     = '0;
    for (int k = 1; k <= 4; k++) begin
      cand = ptr + k[1:0];
      if (!pick_vld && bus.req[cand]) begin
        pick     = cand;
        pick_vld = 1'b1;
      end
    end
  end

  // A balance load in IDLE takes the cycle and blocks arbitration.
  assign start  = (state == IDLE) && !bus.cargarBalance && pick_vld;
  assign sum    = {1'b0, balance_q} + {33'b0, monto_q};
  assign enough = ({32'b0, monto_q} <= balance_q);

  // State register
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = IDLE;
    case (state)
      IDLE:    state_nxt = start ? GRANT : IDLE;
      GRANT:   state_nxt = EXEC;
      EXEC:    state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: operand latch, balance engine, result flags, priority pointer.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr       <= 2'd3;
      idx       <= '0;
      retiro_q  <= 1'b0;
      monto_q   <= '0;
      balance_q <= '0;
      upd_q     <= 1'b0;
      ent_q     <= 1'b0;
      ins_q     <= 1'b0;
    end else begin
      // Flags live for exactly the RESP cycle that follows EXEC.
      upd_q <= 1'b0;
      ent_q <= 1'b0;
      ins_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.cargarBalance) begin
            balance_q <= bus.balanceInicial;
          end else if (pick_vld) begin
            idx      <= pick;
            retiro_q <= bus.tipoTrans[pick];
            monto_q  <= bus.monto[{pick, 5'd0} +: 32];
          end
        end
        EXEC: begin
          if (!retiro_q) begin
            balance_q <= sum[64] ? {64{1'b1}} : sum[63:0];
            upd_q     <= 1'b1;
          end else if (enough) begin
            balance_q <= balance_q - {32'b0, monto_q};
            upd_q     <= 1'b1;
            ent_q     <= 1'b1;
          end else begin
            ins_q     <= 1'b1;
          end
        end
        RESP:    ptr <= idx;
        default: ;
      endcase
    end
  end

  // Output logic
  always_comb begin
    bus.grant   = '0;
    bus.ack     = '0;
    bus.ocupado = (state != IDLE);
    case (state)
      GRANT, EXEC: bus.grant[idx] = 1'b1;
      RESP: begin
        bus.grant[idx] = 1'b1;
        bus.ack[idx]   = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.balance             = balance_q;
  assign bus.balanceActualizado  = upd_q;
  assign bus.entregarDinero      = ent_q;
  assign bus.fondosInsuficientes = ins_q;

endmodule
